// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end for a single-port, write-first data RAM with a
// registered read address and no byte enables. It takes one CPU request at a
// time, turns the byte address into a word address, performs byte/half/word
// loads with sign or zero extension, and performs sub-word stores as a
// read-modify-write of the whole RAM word. Each accepted request produces
// exactly one single-cycle response pulse. Misaligned or illegal-size requests
// produce an error response and never touch the RAM.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   reset_i        asynchronous, active-high reset
//   req_valid_i    request present
//   req_ready_o    unit can accept (high only in IDLE)
//   req_we_i       1 = store, 0 = load
//   req_size_i     00 byte, 01 half, 10 word, 11 illegal
//   req_signed_i   loads: 1 sign-extend, 0 zero-extend
//   req_addr_i     byte address (ADDR_WIDTH+2 bits)
//   req_wdata_i    store data, right-justified for sub-word stores
//   resp_valid_o   one-cycle response pulse (registered)
//   resp_rdata_o   load result, 0 for stores and errors (registered)
//   resp_error_o   qualifies resp_valid_o: misaligned / illegal size
//   ram_addr_o     RAM word address (registered)
//   ram_data_o     RAM write data
//   ram_we_o       RAM write enable, decoded from state
//   ram_q_i        RAM read data, valid the cycle after ram_addr_o is sampled
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_error_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_q_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]            state_q, state_d;

  // request fields captured at the accepting edge
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_error_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;

  logic                  accept;
  logic                  misaligned;
  logic [4:0]            byte_sh;
  logic [4:0]            half_sh;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = req_valid_i & (state_q == S_IDLE);

  assign misaligned = (req_size_i == 2'b11) ||
                      ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                      ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

  // little-endian lane offsets: byte lane n at bits 8n, half lane at 16*addr[1]
  assign byte_sh = {lane_q, 3'b000};
  assign half_sh = {lane_q[1], 4'b0000};
  assign byte_v  = ram_q_i[byte_sh +: 8];
  assign half_v  = ram_q_i[half_sh +: 16];

  always_comb begin
    load_val = ram_q_i;
    case (size_q)
      SZ_BYTE: load_val = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      SZ_HALF: load_val = signed_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: load_val = ram_q_i;
    endcase
  end

  // sub-word store: keep the lanes just read, replace only the addressed one
  always_comb begin
    merged = ram_q_i;
    case (size_q)
      SZ_BYTE: merged[byte_sh +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[half_sh +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !misaligned)
          state_d = (req_we_i && (req_size_i == SZ_WORD)) ? S_WR : S_RD;
      end
      S_RD:    state_d = we_q ? S_MERGE : S_CAP;
      S_CAP:   state_d = S_IDLE;
      S_MERGE: state_d = S_IDLE;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      // response is a pulse: default low, raised only in completing states
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            lane_q   <= req_addr_i[1:0];
            wdata_q  <= req_wdata_i;
            if (misaligned) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              ram_addr_q <= req_addr_i[ADDR_WIDTH+1:2];
              if (req_we_i && (req_size_i == SZ_WORD))
                ram_data_q <= req_wdata_i;
            end
          end
        end
        S_CAP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_val;
        end
        S_MERGE: begin
          // keep the merged word on ram_data_o after the write completes
          ram_data_q   <= merged;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        S_WR: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_error_o = resp_error_q;
  assign ram_addr_o   = ram_addr_q;
  // write enable decoded from state so an async reset kills a pending write
  assign ram_we_o     = (state_q == S_MERGE) || (state_q == S_WR);
  // in MERGE the write word comes straight from the RAM read data
  assign ram_data_o   = (state_q == S_MERGE) ? merged : ram_data_q;

endmodule
